// File: rtl/edge_event_pkg.sv
// ============================================================================
//  Module   : edge_event_pkg
//  Brief    : Shared edge-mode type, channel limit and edge-select helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package edge_event_pkg;

  localparam int unsigned MAX_CH = 32;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    BOTH = 2'd3
  } edge_mode_t;

  function automatic logic edge_select(edge_mode_t m, logic rise, logic fall);
    logic r;
    case (m)
      NONE:    r = 1'b0;
      RISE:    r = rise;
      FALL:    r = fall;
      default: r = rise | fall;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_debounce_filter.sv
// ============================================================================
//  Module   : edge_debounce_filter
//  Brief    : Per-channel level qualifier; debounces when EDGE_EVENT_DEBOUNCE_EN
//             is defined, otherwise a pure pass-through.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_debounce_filter #(
  parameter int unsigned DEBOUNCE_CYCLES     = 4,
  parameter bit          INITIAL_INPUT_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clk_en_i,
  input  logic level_i,
  output logic level_o
);

`ifdef EDGE_EVENT_DEBOUNCE_EN

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       level_q, level_d;
  logic [7:0] cnt_q,   cnt_d;

  // The count tracks consecutive enabled samples that disagree with the
  // qualified level; any agreeing sample restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (clk_en_i) begin
      if (level_i == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = level_i;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      level_q <= INITIAL_INPUT_LEVEL;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

`else

  logic w_unused;
  assign w_unused = &{1'b0, clk_i, reset_n_i, clk_en_i, DEBOUNCE_CYCLES[0]};
  assign level_o  = level_i;

`endif

endmodule

`default_nettype wire

// File: rtl/edge_event_unit.sv
// ============================================================================
//  Module   : edge_event_unit
//  Brief    : Multi-channel synchronise / qualify / edge-detect unit with
//             sticky pending and overrun flags and a combined interrupt.
//             Optional debounce: define EDGE_EVENT_DEBOUNCE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_event_unit
  import edge_event_pkg::*;
#(
  parameter int unsigned NUM_CH              = 8,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned DEBOUNCE_CYCLES     = 4,
  parameter bit          INITIAL_INPUT_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic [NUM_CH-1:0]     in,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [NUM_CH-1:0]     clr,
  output logic [NUM_CH-1:0]     edge_pulse,
  output logic [NUM_CH-1:0]     pending,
  output logic [NUM_CH-1:0]     overrun,
  output logic                  irq
);

  localparam logic [NUM_CH-1:0] INIT_VEC = {NUM_CH{INITIAL_INPUT_LEVEL}};

  logic [NUM_CH-1:0] w_sync;
  logic [NUM_CH-1:0] w_qual;
  logic [NUM_CH-1:0] w_det;

  logic [NUM_CH-1:0] prev_q,       prev_d;
  logic [NUM_CH-1:0] edge_pulse_q, edge_pulse_d;
  logic [NUM_CH-1:0] pending_q,    pending_d;
  logic [NUM_CH-1:0] overrun_q,    overrun_d;

  // Channel counts above MAX_CH are outside the supported range.
  logic w_unused_cfg;
  assign w_unused_cfg = (NUM_CH > MAX_CH);

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_sync = in;
  end else begin : g_sync
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s < int'(SYNC_STAGES); s++) begin
          sync_q[s] <= INIT_VEC;
        end
      end else if (clk_en) begin
        sync_q[0] <= in;
        for (int s = 1; s < int'(SYNC_STAGES); s++) begin
          sync_q[s] <= sync_q[s-1];
        end
      end
    end

    assign w_sync = sync_q[SYNC_STAGES-1];
  end

  for (genvar ch = 0; ch < int'(NUM_CH); ch++) begin : g_ch
    edge_debounce_filter #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .INITIAL_INPUT_LEVEL (INITIAL_INPUT_LEVEL)
    ) u_filter (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .clk_en_i  (clk_en),
      .level_i   (w_sync[ch]),
      .level_o   (w_qual[ch])
    );
  end

  // History follows the qualified level under every mode, so a mode switch
  // only masks edges and can never fabricate one.
  always_comb begin
    w_det = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_det[i] = edge_select(edge_mode_t'(mode[2*i +: 2]),
                             w_qual[i] & ~prev_q[i],
                             ~w_qual[i] & prev_q[i]);
    end
  end

  always_comb begin
    prev_d       = clk_en ? w_qual : prev_q;
    edge_pulse_d = clk_en ? w_det  : '0;
    pending_d    = (pending_q & ~clr) | edge_pulse_q;
    overrun_d    = (overrun_q & ~clr) | (edge_pulse_q & pending_q & ~clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= INIT_VEC;
      edge_pulse_q <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
    end else begin
      prev_q       <= prev_d;
      edge_pulse_q <= edge_pulse_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
    end
  end

  assign edge_pulse = edge_pulse_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;
  assign irq        = |pending_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_event_unit.sv
// ============================================================================
//  Module   : tb_edge_event_unit
//  Brief    : Randomised self-checking bench for edge_event_unit against a
//             sample-history reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_event_unit;

  localparam int NCH  = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam bit INIT = 1'b0;
`ifdef EDGE_EVENT_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clk_en;
  logic [NCH-1:0]   in_v;
  logic [2*NCH-1:0] mode_v;
  logic [NCH-1:0]   clr_v;
  logic [NCH-1:0]   edge_pulse;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   overrun;
  logic             irq;

  edge_event_unit #(
    .NUM_CH              (NCH),
    .SYNC_STAGES         (SYNC),
    .DEBOUNCE_CYCLES     (DEB),
    .INITIAL_INPUT_LEVEL (INIT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_en     (clk_en),
    .in         (in_v),
    .mode       (mode_v),
    .clr        (clr_v),
    .edge_pulse (edge_pulse),
    .pending    (pending),
    .overrun    (overrun),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  string phase = "reset";

  // Reference model: full history of enabled-cycle input samples.
  logic [NCH-1:0] xh[$];
  logic [NCH-1:0] m_qa, m_last, m_pulse, m_pend, m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Level leaving the synchroniser before enabled edge k (1-based).
  function automatic logic [NCH-1:0] z_at(input int k);
    if (k - SYNC >= 1) return xh[k-SYNC-1];
    return {NCH{INIT}};
  endfunction

  task automatic model_reset();
    xh.delete();
    m_qa    = {NCH{INIT}};
    m_last  = {NCH{INIT}};
    m_pulse = '0;
    m_pend  = '0;
    m_ovr   = '0;
  endtask

  task automatic model_clock();
    logic [NCH-1:0] lvl, det, newq, zz;
    logic rise, fall;
    int k;
    m_ovr  = (m_ovr & ~clr_v) | (m_pulse & m_pend & ~clr_v);
    m_pend = (m_pend & ~clr_v) | m_pulse;
    if (clk_en) begin
      xh.push_back(in_v);
      k = xh.size();
      if (DEB_ON) begin
        lvl  = m_qa;
        newq = m_qa;
        for (int b = 0; b < NCH; b++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int j = 0; j < DEB; j++) begin
            zz = z_at(k - j);
            if (zz[b] == m_qa[b]) all_diff = 1'b0;
          end
          if (all_diff) newq[b] = ~m_qa[b];
        end
        m_qa = newq;
      end else begin
        lvl = z_at(k);
      end
      det = '0;
      for (int b = 0; b < NCH; b++) begin
        rise = lvl[b] & ~m_last[b];
        fall = ~lvl[b] & m_last[b];
        case (mode_v[2*b +: 2])
          2'd0:    det[b] = 1'b0;
          2'd1:    det[b] = rise;
          2'd2:    det[b] = fall;
          default: det[b] = rise | fall;
        endcase
      end
      m_last  = lvl;
      m_pulse = det;
    end else begin
      m_pulse = '0;
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".pulse"},   32'(edge_pulse), 32'(m_pulse));
    check({ph, ".pending"}, 32'(pending),    32'(m_pend));
    check({ph, ".overrun"}, 32'(overrun),    32'(m_ovr));
    check({ph, ".irq"},     32'(irq),        32'(|m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_all(phase);
  endtask

  // Called at a falling edge; asserts reset between clock edges.
  task automatic async_reset(input string ph);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all({ph, ".async"});
    @(negedge clk);
    check_all({ph, ".held"});
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int npulse, at, lat_exp, cyc;
    bit found;
    logic [NCH-1:0] flip;

    reset_n = 1'b0;
    clk_en  = 1'b0;
    in_v    = '0;
    mode_v  = '0;
    clr_v   = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    clk_en  = 1'b1;
    lat_exp = SYNC + 1 + (DEB_ON ? DEB : 0);

    // Single rising edge on channel 0
    phase = "rise0";
    mode_v[1:0] = 2'd1;
    in_v[0] = 1'b1;
    npulse = 0; at = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (edge_pulse[0]) begin npulse++; at = i + 1; end
    end
    check("rise0.count", npulse, 1);
    check("rise0.latency", at, lat_exp);

    // Both edges on channel 1, second one overruns; then clear
    phase = "both1";
    mode_v[3:2] = 2'd3;
    in_v[1] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    in_v[1] = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("both1.overrun", 32'(overrun[1]), 1);
    clr_v[1:0] = 2'b11;
    step();
    clr_v = '0;
    step();
    check("both1.pend_clr", 32'(pending[1]), 0);
    check("both1.ovr_clr", 32'(overrun[1]), 0);
    check("both1.irq_clr", 32'(irq), 0);

    // Short glitch then stable high on channel 2
    phase = "glitch2";
    mode_v[5:4] = 2'd1;
    npulse = 0;
    in_v[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); if (edge_pulse[2]) npulse++; end
    in_v[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); if (edge_pulse[2]) npulse++; end
    check("glitch2.glitch_pulses", npulse, DEB_ON ? 0 : 1);
    for (int i = 0; i < 6; i++) step();
    clr_v[2] = 1'b1; step(); clr_v = '0;
    in_v[2] = 1'b1;
    npulse = 0; at = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (edge_pulse[2]) begin npulse++; at = i + 1; end
    end
    check("glitch2.stable_pulses", npulse, 1);
    check("glitch2.latency", at, lat_exp);

    // Clear coinciding with an edge pulse on channel 3
    phase = "collide3";
    mode_v[7:6] = 2'd1;
    in_v[3] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    in_v[3] = 1'b0;
    for (int i = 0; i < 10; i++) step();
    in_v[3] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (m_pulse[3]) begin
        clr_v[3] = 1'b1;
        step();
        clr_v[3] = 1'b0;
        found = 1'b1;
      end
    end
    check("collide3.pulse_seen", 32'(found), 1);
    check("collide3.pending", 32'(pending[3]), 1);
    check("collide3.overrun", 32'(overrun[3]), 0);

    // Sparse clock enable: one enabled cycle in three
    phase = "sparse_en";
    mode_v[9:8] = 2'd3;
    cyc = 0;
    for (int i = 0; i < 90; i++) begin
      clk_en = (cyc % 3 == 0);
      if (cyc % 20 == 0) in_v[4] = ~in_v[4];
      cyc++;
      step();
    end
    clk_en = 1'b1;

    // Randomised operation with occasional asynchronous resets
    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < NCH; b++) flip[b] = ($urandom_range(0, 4) == 0);
      in_v = in_v ^ flip;
      if ($urandom_range(0, 15) == 0) mode_v = 16'($urandom);
      for (int b = 0; b < NCH; b++) clr_v[b] = ($urandom_range(0, 7) == 0);
      step();
      if ($urandom_range(0, 299) == 0) async_reset("random");
    end
    clr_v  = '0;
    clk_en = 1'b1;

    // Fill all pending bits, then reset asynchronously
    phase = "fill";
    mode_v = '1;
    in_v   = ~in_v;
    for (int i = 0; i < 12; i++) step();
    check("fill.pending_all", 32'(pending), 32'hFF);
    async_reset("rst_mid");
    phase = "post_rst";
    in_v = '0;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (edge_pulse != '0) npulse++;
    end
    check("post_rst.pulses", npulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/edge_event_unit.md
EDGE_EVENT_UNIT -- requirements
Module: edge_event_unit

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of independent input channels, range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per channel, range 0..3; 0 means inputs are already synchronous.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4: stable-level qualification length in clk_en cycles, range 1..255; used only with EDGE_EVENT_DEBOUNCE_EN.
REQ-004 SHALL have parameter INITIAL_INPUT_LEVEL, default 0: reset value of all per-channel level history.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port clk_en, input, 1 bit: sample enable for the synchroniser, debounce and history pipeline.
REQ-008 SHALL have port in, input, NUM_CH bits: raw channel levels.
REQ-009 SHALL have port mode, input, 2*NUM_CH bits: per-channel edge_mode_t, where 0=NONE, 1=RISE, 2=FALL, 3=BOTH.
REQ-010 SHALL have port clr, input, NUM_CH bits: write-1-to-clear for pending and overrun.
REQ-011 SHALL have port edge_pulse, output, NUM_CH bits: one-cycle registered edge strobe.
REQ-012 SHALL have port pending, output, NUM_CH bits: sticky event flag.
REQ-013 SHALL have port overrun, output, NUM_CH bits: sticky flag for an edge that arrives while pending is set.
REQ-014 SHALL have port irq, output, 1 bit: OR of all pending bits.

Function
REQ-015 Each channel SHALL pass through SYNC_STAGES flops, then the qualifier, then one history flop (prev); all of these advance only when clk_en=1.
REQ-016 Without debounce, the qualified level SHALL equal the synchroniser output.
REQ-017 Edge detection SHALL be: rise = qual & ~prev, fall = ~qual & prev; the mode mask selects rise, fall, both, or none.
REQ-018 edge_pulse SHALL be registered, high for exactly one clk cycle, and only in cycles where clk_en=1; when clk_en=0 it is 0.
REQ-019 Latency from a changed input to edge_pulse SHALL be SYNC_STAGES+1 clk_en cycles without debounce, and SYNC_STAGES+DEBOUNCE_CYCLES+1 clk_en cycles with debounce.
REQ-020 A mode change SHALL take effect on the next cycle; because history keeps tracking under every mode, switching mode never creates a spurious edge.
REQ-021 pending[i] SHALL set on edge_pulse[i] and clear on clr[i]; if both occur in the same cycle, set wins.
REQ-022 overrun[i] SHALL set when edge_pulse[i]=1 while pending[i]=1 and clr[i]=0; clr[i] clears it; if both occur, set wins.
REQ-023 clr and the pending/overrun update SHALL act on every clk cycle, regardless of clk_en.
REQ-024 irq SHALL be combinational OR of pending, with no added latency.

Reset
REQ-025 reset_n=0 SHALL asynchronously force every synchroniser, qualifier and prev flop to INITIAL_INPUT_LEVEL.
REQ-026 reset_n=0 SHALL asynchronously force debounce counters, edge_pulse, pending, overrun and irq to 0.
REQ-027 After reset release, no edge SHALL be reported while the input equals INITIAL_INPUT_LEVEL.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count.

Configuration
REQ-029 Macro EDGE_EVENT_DEBOUNCE_EN defined: the qualified level SHALL update only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive clk_en cycles; any reversion restarts the count at 0.
REQ-030 Macro EDGE_EVENT_DEBOUNCE_EN undefined: no counter logic SHALL be present, DEBOUNCE_CYCLES is ignored, and REQ-016 applies.

Structure
REQ-031 Package edge_event_pkg SHALL hold edge_mode_t (2-bit enum NONE/RISE/FALL/BOTH) and the MAX_CH=32 constant.
REQ-032 Per-channel qualification SHALL live in sub-module edge_debounce_filter, instantiated NUM_CH times via generate; it is a pass-through when the macro is off.

Verification
REQ-033 Defaults, no debounce, mode[1:0]=RISE, in[0] 0->1 held, clk_en=1: edge_pulse[0] high exactly once, 3 cycles after the change; pending[0]=1 and irq=1 from the next cycle.
REQ-034 mode=BOTH, in[1] 0->1 then 1->0 10 cycles apart, no clr: two pulses; overrun[1]=1 after the second; clr[1]=1 for 1 cycle clears both flags and irq.
REQ-035 Debounce on, DEBOUNCE_CYCLES=4, in[2] 3-cycle glitch, then 6-cycle high: no pulse for the glitch; one pulse at SYNC+4+1 cycles into the stable high.
REQ-036 clr[3] and edge_pulse[3] in the same cycle: pending[3] stays 1 and overrun[3] is unchanged.
REQ-037 clk_en toggling 1-of-3 cycles: latency is counted in enabled cycles, and pulse width is 1 clk.
REQ-038 reset_n asserted mid-operation with pending=8'hFF: all outputs are 0 immediately (asynchronously), and in=0 after release yields no pulses.
